sha2_round_engine: RTL and testbench
====================================

SHA2_ROUND_ENGINE -- requirements
Module: sha2_round_engine

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning compression word width: 32 selects SHA-224/256, 64 selects SHA-384/512, and any other value is an elaboration error.
REQ-002 SHALL have derived parameter ROUNDS, value 64 when WORD_W=32 and 80 when WORD_W=64, meaning the number of compression rounds.
REQ-003 SHALL have clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have rstn  in  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have start  in  1  request to compress one block; accepted only when ready=1.
REQ-006 SHALL have ready  out  1  engine can accept start this cycle.
REQ-007 SHALL have block_i  in  16*WORD_W  message block, with W[0] in the MSBs.
REQ-008 SHALL have hash_i  in  8*WORD_W  chaining value H0..H7, with H0 in the MSBs.
REQ-009 SHALL have round_o  out  7  index t of the round executing this cycle.
REQ-010 SHALL have k_i  in  WORD_W  round constant K[round_o], supplied combinationally in the same cycle.
REQ-011 SHALL have done  out  1  single-cycle pulse marking hash_o valid.
REQ-012 SHALL have hash_o  out  8*WORD_W  result, with word a/H0 in the MSBs, held until the next accept.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, with transitions IDLE->RUN on accept, RUN->DONE after round ROUNDS-1, DONE->IDLE, and DONE->RUN on accept.
REQ-014 SHALL drive ready=1 in IDLE and DONE, and ready=0 in RUN.
REQ-015 SHALL, on accept, latch block_i and hash_i, load a..h from hash_i and the 16-word schedule window from block_i, and clear round_o to 0.
REQ-016 SHALL ignore start while in RUN, with no state change.
REQ-017 SHALL execute exactly one round per RUN cycle: T1=h+Σ1(e)+Ch(e,f,g)+k_i+Wt; T2=Σ0(a)+Maj(a,b,c); a<=T1+T2; e<=d+T1; b,c,d and f,g,h shift as in FIPS 180-4; all additions are modulo 2^WORD_W.
REQ-018 SHALL take Wt from window slot 0; each round the window shifts down by one word and appends σ1(W[14])+W[9]+σ0(W[1])+W[0].
REQ-019 SHALL use these rotate amounts for WORD_W=32: Σ0 2/13/22, Σ1 6/11/25, σ0 ROTR7, ROTR18, SHR3, σ1 ROTR17, ROTR19, SHR10.
REQ-020 SHALL use these rotate amounts for WORD_W=64: Σ0 28/34/39, Σ1 14/18/41, σ0 ROTR1, ROTR8, SHR7, σ1 ROTR19, ROTR61, SHR6.
REQ-021 SHALL increment round_o each RUN cycle and hold it at 0 outside RUN.
REQ-022 SHALL update hash_o on the RUN->DONE edge and assert done for exactly the DONE cycle.
REQ-023 SHALL give a latency from the accept edge to the done=1 cycle of ROUNDS+1 cycles.
REQ-024 SHALL accept back-to-back blocks: start in DONE begins the next block while hash_o of the previous block stays valid for that cycle.
REQ-025 SHALL NOT require any truncation for SHA-224/384; consumers select the leading words.

Reset
REQ-026 SHALL, while rstn=0, force the FSM to IDLE and clear ready, done, round_o, hash_o, a..h, the window and the latches to 0.
REQ-027 SHALL drive ready=1 on the first clock edge after rstn deasserts.
REQ-028 SHALL abandon an in-flight block when reset is asserted mid-RUN, and SHALL never pulse done for that block.

Configuration
REQ-029 SHALL, when macro SHA2_FEEDFORWARD_EN is defined, produce hash_o word i = latched hash_i word i + final working variable i, modulo 2^WORD_W.
REQ-030 SHALL, when SHA2_FEEDFORWARD_EN is undefined, produce hash_o = final a..h unmodified, for an external adder; timing and handshake are identical in both builds.

Verification
REQ-031 SHALL cover: WORD_W=32 with feed-forward, FIPS IV, block 61626380 followed by zeros and last word 00000018 -> done at accept+65, hash_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-032 SHALL cover: WORD_W=64 with feed-forward, SHA-512 IV, "abc" padded block -> done at accept+81, hash_o leading word ddaf35a193617aba and final word a54ca49f.
REQ-033 SHALL cover: the REQ-031 stimulus with SHA2_FEEDFORWARD_EN undefined -> each hash_o word equals the REQ-031 digest word minus the IV word, modulo 2^32.
REQ-034 SHALL cover: start pulsed at round_o=10 and 40 of a block -> ignored, with the REQ-031 digest unchanged and done pulsed once.
REQ-035 SHALL cover: rstn low for 1 cycle at round_o=20 -> all outputs 0, ready=1 after release, no done; then a fresh "abc" -> correct digest.
REQ-036 SHALL cover: two blocks with start held high through DONE -> second accept in the DONE cycle, with done pulses 65 cycles apart.

Source files
------------

// File: rtl/sha2_round_engine_if.sv
// Handshake and data bus of the SHA-2 round engine; the master also supplies K[round_o].
interface sha2_round_engine_if #(
  parameter int WORD_W = 32
);
  logic                  start;
  logic                  ready;
  logic [16*WORD_W-1:0]  block_i;
  logic [8*WORD_W-1:0]   hash_i;
  logic [6:0]            round_o;
  logic [WORD_W-1:0]     k_i;
  logic                  done;
  logic [8*WORD_W-1:0]   hash_o;

  modport master (
    output start, block_i, hash_i, k_i,
    input  ready, round_o, done, hash_o
  );

  modport slave (
    input  start, block_i, hash_i, k_i,
    output ready, round_o, done, hash_o
  );
endinterface

// File: rtl/sha2_round_engine.sv
// SHA-2 compression engine, one round per clock (SHA-224/256 or SHA-384/512 by WORD_W).
// Define SHA2_FEEDFORWARD_EN to fold the chaining value into hash_o; otherwise hash_o is raw a..h.
module sha2_round_engine #(
  parameter  int WORD_W = 32,
  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64
) (
  input logic                clk,
  input logic                rstn,
  sha2_round_engine_if.slave bus
);
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $fatal(1, "sha2_round_engine: WORD_W must be 32 or 64");
  end

  localparam int BS0_A = (WORD_W == 64) ? 28 : 2;
  localparam int BS0_B = (WORD_W == 64) ? 34 : 13;
  localparam int BS0_C = (WORD_W == 64) ? 39 : 22;
  localparam int BS1_A = (WORD_W == 64) ? 14 : 6;
  localparam int BS1_B = (WORD_W == 64) ? 18 : 11;
  localparam int BS1_C = (WORD_W == 64) ? 41 : 25;
  localparam int SS0_A = (WORD_W == 64) ? 1  : 7;
  localparam int SS0_B = (WORD_W == 64) ? 8  : 18;
  localparam int SS0_S = (WORD_W == 64) ? 7  : 3;
  localparam int SS1_A = (WORD_W == 64) ? 19 : 17;
  localparam int SS1_B = (WORD_W == 64) ? 61 : 19;
  localparam int SS1_S = (WORD_W == 64) ? 6  : 10;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
  endfunction

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [6:0]           round_q;
  word_t                v_q  [8];
  word_t                v_nx [8];
  word_t                w_q  [16];
  word_t                w_new, t1, t2;
  logic [8*WORD_W-1:0]  result, hash_o_q;
  logic                 accept, last_round;

  assign accept     = bus.start && ready_q;
  assign last_round = (round_q == 7'(ROUNDS - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_round) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One compression round and one schedule-window extension.
  always_comb begin
    t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + bus.k_i + w_q[0];
    t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    v_nx[0] = t1 + t2;
    v_nx[1] = v_q[0];
    v_nx[2] = v_q[1];
    v_nx[3] = v_q[2];
    v_nx[4] = v_q[3] + t1;
    v_nx[5] = v_q[4];
    v_nx[6] = v_q[5];
    v_nx[7] = v_q[6];
    w_new   = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

`ifdef SHA2_FEEDFORWARD_EN
  word_t hash_q [8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) hash_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 8; i++) hash_q[i] <= bus.hash_i[(7-i)*WORD_W +: WORD_W];
    end
  end
`endif

  always_comb begin
    result = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SHA2_FEEDFORWARD_EN
      result[(7-i)*WORD_W +: WORD_W] = hash_q[i] + v_nx[i];
`else
      result[(7-i)*WORD_W +: WORD_W] = v_nx[i];
`endif
    end
  end

  // NOTE: all state uses non-blocking assignments; the working variables and the
  // schedule window are plain registers, so they are cleared by reset like the rest.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      round_q  <= '0;
      hash_o_q <= '0;
      for (int i = 0; i < 8; i++)  v_q[i] <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_RUN);
      if (accept) begin
        round_q <= '0;
        for (int i = 0; i < 8; i++)  v_q[i] <= bus.hash_i[(7-i)*WORD_W +: WORD_W];
        for (int i = 0; i < 16; i++) w_q[i] <= bus.block_i[(15-i)*WORD_W +: WORD_W];
      end else if (state_q == S_RUN) begin
        for (int i = 0; i < 8; i++)  v_q[i] <= v_nx[i];
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= w_new;
        round_q <= last_round ? 7'd0 : round_q + 7'd1;
        if (last_round) hash_o_q <= result;
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = (state_q == S_DONE);
  assign bus.round_o = round_q;
  assign bus.hash_o  = hash_o_q;
endmodule

// File: tb/tb_sha2_round_engine.sv
// Bench for sha2_round_engine: a 32-bit and a 64-bit engine against a FIPS 180-4 reference model.
module tb_sha2_round_engine;
`ifdef SHA2_FEEDFORWARD_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  // SHA-512 constants; the upper halves of the first 64 are the SHA-256 constants.
  localparam logic [63:0] KTAB [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [255:0] D256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sha2_round_engine_if #(.WORD_W(32)) if32 ();
  sha2_round_engine_if #(.WORD_W(64)) if64 ();

  sha2_round_engine #(.WORD_W(32)) dut32 (.clk(clk), .rstn(rstn), .bus(if32));
  sha2_round_engine #(.WORD_W(64)) dut64 (.clk(clk), .rstn(rstn), .bus(if64));

  // Bench-side stimulus in a common format: 64-bit slots, word 0 in the MSB slot.
  logic [1023:0] blk_src [2];
  logic [511:0]  hs_src  [2];
  bit            start_src [2];

  function automatic logic [511:0] narrow_blk(input logic [1023:0] x);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = x[i*64 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] narrow_h(input logic [511:0] x);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*64 +: 32];
    return r;
  endfunction

  function automatic logic [511:0] widen_h(input logic [255:0] x);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = {32'h0, x[i*32 +: 32]};
    return r;
  endfunction

  assign if32.start   = start_src[0];
  assign if64.start   = start_src[1];
  assign if32.block_i = narrow_blk(blk_src[0]);
  assign if64.block_i = blk_src[1];
  assign if32.hash_i  = narrow_h(hs_src[0]);
  assign if64.hash_i  = hs_src[1];
  assign if32.k_i     = (if32.round_o < 7'd64) ? KTAB[if32.round_o][63:32] : 32'h0;
  assign if64.k_i     = (if64.round_o < 7'd80) ? KTAB[if64.round_o] : 64'h0;

  // ---------------- reference model (full message schedule, FIPS 180-4 style) ----------------
  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & msk(w);
  endfunction

  function automatic logic [63:0] bs0(input logic [63:0] x, input int w);
    return (w == 64) ? rr(x, 28, w) ^ rr(x, 34, w) ^ rr(x, 39, w) : rr(x, 2, w) ^ rr(x, 13, w) ^ rr(x, 22, w);
  endfunction

  function automatic logic [63:0] bs1(input logic [63:0] x, input int w);
    return (w == 64) ? rr(x, 14, w) ^ rr(x, 18, w) ^ rr(x, 41, w) : rr(x, 6, w) ^ rr(x, 11, w) ^ rr(x, 25, w);
  endfunction

  function automatic logic [63:0] ss0(input logic [63:0] x, input int w);
    return (w == 64) ? rr(x, 1, w) ^ rr(x, 8, w) ^ (x >> 7) : rr(x, 7, w) ^ rr(x, 18, w) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] ss1(input logic [63:0] x, input int w);
    return (w == 64) ? rr(x, 19, w) ^ rr(x, 61, w) ^ (x >> 6) : rr(x, 17, w) ^ rr(x, 19, w) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] compress(input int w, input logic [1023:0] blk,
                                            input logic [511:0] hin, input bit ff);
    logic [63:0]  m, kt, t1, t2;
    logic [63:0]  ww [80];
    logic [63:0]  v  [8];
    logic [511:0] res;
    int           r;
    m = msk(w);
    r = (w == 64) ? 80 : 64;
    for (int t = 0; t < 80; t++) ww[t] = '0;
    for (int t = 0; t < 16; t++) ww[t] = blk[(15-t)*64 +: 64] & m;
    for (int t = 16; t < r; t++) ww[t] = (ss1(ww[t-2], w) + ww[t-7] + ss0(ww[t-15], w) + ww[t-16]) & m;
    for (int i = 0; i < 8; i++) v[i] = hin[(7-i)*64 +: 64] & m;
    for (int t = 0; t < r; t++) begin
      kt = (w == 64) ? KTAB[t] : (KTAB[t] >> 32);
      t1 = (v[7] + bs1(v[4], w) + ((v[4] & v[5]) ^ (~v[4] & v[6] & m)) + kt + ww[t]) & m;
      t2 = (bs0(v[0], w) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & m;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = (v[3] + t1) & m;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = (t1 + t2) & m;
    end
    for (int i = 0; i < 8; i++)
      res[(7-i)*64 +: 64] = (ff ? v[i] + hin[(7-i)*64 +: 64] : v[i]) & m;
    return res;
  endfunction

  // Cycle-level expectation: run_cnt = -1 idle, 0..R-1 round in progress, R = done cycle.
  int           run_cnt [2] = '{-1, -1};
  bit           m_ready [2] = '{1'b0, 1'b0};
  logic [511:0] m_pend  [2] = '{512'h0, 512'h0};
  logic [511:0] m_hold  [2] = '{512'h0, 512'h0};
  bit           sb_on = 1'b0;
  int           total = 0;
  int           bad   = 0;

  task automatic model_step(input int n, input bit st);
    int r;
    r = (n == 1) ? 80 : 64;
    if (!rstn) begin
      run_cnt[n] = -1;
      m_ready[n] = 1'b0;
      m_hold[n]  = '0;
    end else begin
      if (m_ready[n] && st) begin
        m_pend[n]  = compress((n == 1) ? 64 : 32, blk_src[n], hs_src[n], FF);
        run_cnt[n] = 0;
      end else if (run_cnt[n] >= 0 && run_cnt[n] < r - 1) begin
        run_cnt[n]++;
      end else if (run_cnt[n] == r - 1) begin
        run_cnt[n] = r;
        m_hold[n]  = m_pend[n];
      end else begin
        run_cnt[n] = -1;
      end
      m_ready[n] = !(run_cnt[n] >= 0 && run_cnt[n] < r);
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    model_step(0, start_src[0]);
    model_step(1, start_src[1]);
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int cur_round(input int n);
    return (n == 1) ? int'(if64.round_o) : int'(if32.round_o);
  endfunction

  function automatic logic cur_done(input int n);
    return (n == 1) ? if64.done : if32.done;
  endfunction

  function automatic logic cur_ready(input int n);
    return (n == 1) ? if64.ready : if32.ready;
  endfunction

  function automatic logic [511:0] cur_hash(input int n);
    return (n == 1) ? if64.hash_o : widen_h(if32.hash_o);
  endfunction

  // Compare process: every cycle, both engines, all outputs.
  always @(negedge clk) begin
    if (sb_on) begin
      for (int n = 0; n < 2; n++) begin
        automatic int r   = (n == 1) ? 80 : 64;
        automatic bit run = (run_cnt[n] >= 0 && run_cnt[n] < r);
        check((n == 1) ? "sb64_ready" : "sb32_ready", cur_ready(n), m_ready[n]);
        check((n == 1) ? "sb64_done"  : "sb32_done",  cur_done(n),  run_cnt[n] == r);
        check((n == 1) ? "sb64_round" : "sb32_round", cur_round(n), run ? run_cnt[n] : 0);
        check((n == 1) ? "sb64_hash"  : "sb32_hash",  cur_hash(n),  m_hold[n]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [1023:0] make_blk(input logic [63:0] w0, input logic [63:0] w15);
    logic [1023:0] b;
    b = '0;
    b[1023:960] = w0;
    b[63:0]     = w15;
    return b;
  endfunction

  function automatic logic [255:0] sub8(input logic [255:0] d, input logic [255:0] iv);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = d[i*32 +: 32] - iv[i*32 +: 32];
    return r;
  endfunction

  task automatic run_one(input int n, input int poke_a, input int poke_b, input int budget,
                         output int lat, output int ndone, output logic [511:0] res);
    lat = -1; ndone = 0; res = '0;
    start_src[n] = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start_src[n] = 1'b0;
      if (cur_done(n)) begin
        ndone++;
        if (lat < 0) begin lat = c; res = cur_hash(n); end
      end
      if (cur_round(n) == poke_a || cur_round(n) == poke_b) start_src[n] = 1'b1;
    end
    start_src[n] = 1'b0;
  endtask

  initial begin
    int           lat, ndone, d1, d2, cnt;
    bit           found;
    logic [511:0] res, res1, res2;
    logic [255:0] exp32;
    logic [63:0]  e_lead, e_last;
    logic [1023:0] blk_b;

    exp32  = FF ? D256 : sub8(D256, IV256);
    e_lead = 64'hddaf35a193617aba;
    e_last = 64'h2a9ac94fa54ca49f;
    if (!FF) begin
      e_lead = e_lead - IV512[511:448];
      e_last = e_last - IV512[63:0];
    end
    blk_b = '0;
    for (int t = 0; t < 16; t++) blk_b[(15-t)*64 +: 64] = {32'h0, 32'h9e3779b9 * (t + 1)};

    rstn = 1'b0;
    start_src[0] = 1'b0; start_src[1] = 1'b0;
    blk_src[0] = make_blk(64'h61626380, 64'h18);
    blk_src[1] = make_blk(64'h6162638000000000, 64'h18);
    hs_src[0]  = widen_h(IV256);
    hs_src[1]  = IV512;
    @(posedge clk); #1;
    sb_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      check("reset_ready", cur_ready(n), 1'b0);
      check("reset_done",  cur_done(n),  1'b0);
      check("reset_round", cur_round(n), 0);
      check("reset_hash",  cur_hash(n),  '0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    check("first_edge_ready32", if32.ready, 1'b1);
    check("first_edge_ready64", if64.ready, 1'b1);

    // SHA-256 "abc"
    run_one(0, -1, -1, 75, lat, ndone, res);
    check("abc256_latency", lat, 65);
    check("abc256_done_count", ndone, 1);
    check("abc256_digest", narrow_h(res), exp32);

    // SHA-512 "abc"
    run_one(1, -1, -1, 91, lat, ndone, res);
    check("abc512_latency", lat, 81);
    check("abc512_done_count", ndone, 1);
    check("abc512_lead_word", res[511:448], e_lead);
    check("abc512_last_word", res[31:0], e_last[31:0]);

    // SHA-512 second block chained from the first result
    blk_src[1] = blk_b;
    hs_src[1]  = res;
    run_one(1, -1, -1, 91, lat, ndone, res);
    check("chain512_latency", lat, 81);

    // start pulses during RUN must be ignored
    run_one(0, 10, 40, 75, lat, ndone, res);
    check("poke_latency", lat, 65);
    check("poke_done_count", ndone, 1);
    check("poke_digest", narrow_h(res), exp32);

    // reset for one cycle at round 20
    found = 1'b0;
    start_src[0] = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      start_src[0] = 1'b0;
      if (if32.round_o == 7'd20) found = 1'b1;
    end
    check("midrun_reached_round20", found, 1'b1);
    rstn = 1'b0;
    #1;
    check("midrun_rst_ready", if32.ready, 1'b0);
    check("midrun_rst_done",  if32.done,  1'b0);
    check("midrun_rst_round", if32.round_o, 0);
    check("midrun_rst_hash",  if32.hash_o, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("midrun_release_ready", if32.ready, 1'b1);
    cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (if32.done) cnt++;
    end
    check("midrun_no_done", cnt, 0);
    run_one(0, -1, -1, 75, lat, ndone, res);
    check("after_reset_latency", lat, 65);
    check("after_reset_digest", narrow_h(res), exp32);

    // back-to-back with start held through DONE
    d1 = -1; d2 = -1; res1 = '0; res2 = '0;
    start_src[0] = 1'b1;
    for (int c = 1; c <= 200 && d2 < 0; c++) begin
      @(posedge clk); #1;
      if (if32.done) begin
        if (d1 < 0) begin
          d1 = c; res1 = widen_h(if32.hash_o);
          blk_src[0] = blk_b;
        end else begin
          d2 = c; res2 = widen_h(if32.hash_o);
        end
      end
      if (d1 > 0 && c == d1 + 1) start_src[0] = 1'b0;
    end
    start_src[0] = 1'b0;
    check("b2b_first_latency", d1, 65);
    check("b2b_done_spacing", d2 - d1, 65);
    check("b2b_first_digest", narrow_h(res1), exp32);
    check("b2b_second_differs", res2 != res1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    sb_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
